// File: rtl/game_screen_banner.sv
// Character-buffer text renderer for the 96x64 OLED: shadow/live buffers, 4x5 font,
// static/blink/scroll modes advanced per frame, registered RGB565 output.
module game_screen_banner #(
  parameter int          CHARS        = 8,
  parameter int          X0           = 20,
  parameter int          Y0           = 5,
  parameter logic [15:0] FG           = 16'h07E0,
  parameter logic [15:0] BG           = 16'h0000,
  parameter int          BLINK_FRAMES = 16,
  parameter int          SCROLL_DIV   = 2,
  localparam int         AW           = (CHARS > 1) ? $clog2(CHARS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_begin,
  input  logic [6:0]    x,
  input  logic [5:0]    y,
  input  logic [1:0]    mode,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_char,
  output logic [15:0]   oled_data
);

  localparam int SPAN = 96 + 5 * CHARS;
  localparam int DW   = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [AW:0] CHARS_W = CHARS[AW:0];

  // Glyph rows packed MSB-first: bits 19:16 are the top row, bit 3 of a row is the left column.
  function automatic logic [19:0] glyph(input logic [5:0] c);
    case (c)
      6'd1:  glyph = 20'h69F99;  6'd2:  glyph = 20'hE9E9E;  6'd3:  glyph = 20'h78887;
      6'd4:  glyph = 20'hE999E;  6'd5:  glyph = 20'hF8E8F;  6'd6:  glyph = 20'hF8E88;
      6'd7:  glyph = 20'h78B97;  6'd8:  glyph = 20'h99F99;  6'd9:  glyph = 20'hE444E;
      6'd10: glyph = 20'h11196;  6'd11: glyph = 20'h9ACA9;  6'd12: glyph = 20'h8888F;
      6'd13: glyph = 20'h9FF99;  6'd14: glyph = 20'h9DB99;  6'd15: glyph = 20'h69996;
      6'd16: glyph = 20'hE9E88;  6'd17: glyph = 20'h699B7;  6'd18: glyph = 20'hE9EA9;
      6'd19: glyph = 20'h7861E;  6'd20: glyph = 20'hE4444;  6'd21: glyph = 20'h99996;
      6'd22: glyph = 20'h999A4;  6'd23: glyph = 20'h99FF9;  6'd24: glyph = 20'h99699;
      6'd25: glyph = 20'hAA444;  6'd26: glyph = 20'hF168F;  6'd27: glyph = 20'h6BD96;
      6'd28: glyph = 20'h4C44E;  6'd29: glyph = 20'hE168F;  6'd30: glyph = 20'hE161E;
      6'd31: glyph = 20'h99F11;  6'd32: glyph = 20'hF8E1E;  6'd33: glyph = 20'h68E96;
      6'd34: glyph = 20'hF1244;  6'd35: glyph = 20'h69696;  6'd36: glyph = 20'h69716;
      6'd37: glyph = 20'h00004;  6'd38: glyph = 20'h44404;
      default: glyph = 20'h00000;
    endcase
  endfunction

  function automatic logic font_bit(input logic [5:0] c, input logic [2:0] row,
                                    input logic [1:0] col);
    logic [19:0] g;
    logic [4:0]  idx;
    g   = glyph(c);
    idx = 5'd19 - {row, 2'b00} - {3'b000, col};
    font_bit = g[idx];
  endfunction

  logic [5:0]    shadow_q [CHARS];
  logic [5:0]    live_q   [CHARS];
  logic          dirty_q, dirty_d;
  logic          vis_q, vis_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [7:0]    off_q, off_d;
  logic [1:0]    mode_q;
  logic [15:0]   pix_d, oled_q;
  logic          wr_ok, commit;

  assign wr_ok  = wr_en && ({1'b0, wr_addr} < CHARS_W);
  assign commit = frame_begin && dirty_q;

  always_comb begin
    dirty_d = dirty_q;
    if (commit) dirty_d = 1'b0;
    if (wr_ok)  dirty_d = 1'b1;
  end

  // Frame counters; a mode change restarts the animation and outranks frame_begin.
  always_comb begin
    div_d   = div_q;
    off_d   = off_q;
    blink_d = blink_q;
    vis_d   = vis_q;
    if (mode != mode_q) begin
      div_d   = '0;
      off_d   = '0;
      blink_d = '0;
      vis_d   = 1'b1;
    end else if (frame_begin) begin
      if (mode[1]) begin
        if (div_q == DW'(SCROLL_DIV - 1)) begin
          div_d = '0;
          off_d = (off_q == 8'(SPAN - 1)) ? 8'd0 : off_q + 8'd1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      if (mode[0]) begin
        if (blink_q == BW'(BLINK_FRAMES - 1)) begin
          blink_d = '0;
          vis_d   = ~vis_q;
        end else begin
          blink_d = blink_q + 1'b1;
        end
      end
    end
    if (!mode[0]) vis_d = 1'b1;
  end

  logic              scroll;
  logic signed [8:0] xpos;
  logic signed [9:0] dx, dy;

  always_comb begin
    pix_d  = BG;
    scroll = mode[1];
    xpos   = scroll ? (9'sd96 - $signed({1'b0, off_q})) : $signed(9'(X0));
    dx     = $signed({3'b000, x}) - $signed({xpos[8], xpos});
    dy     = $signed({4'b0000, y}) - $signed(10'(Y0));
    if (vis_q && (dy >= 0) && (dy <= 4)) begin
      for (int k = 0; k < CHARS; k++) begin
        if ((dx >= $signed(10'(5 * k))) && (dx <= $signed(10'(5 * k + 3)))) begin
          if (font_bit(live_q[k], dy[2:0], dx[1:0] - 2'(5 * k))) pix_d = FG;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHARS; i++) begin
        shadow_q[i] <= 6'd0;
        live_q[i]   <= 6'd0;
      end
      dirty_q <= 1'b0;
      vis_q   <= 1'b1;
      div_q   <= '0;
      blink_q <= '0;
      off_q   <= '0;
      mode_q  <= 2'b00;
      oled_q  <= BG;
    end else begin
      if (commit) begin
        for (int i = 0; i < CHARS; i++) live_q[i] <= shadow_q[i];
      end
      if (wr_ok) shadow_q[wr_addr] <= wr_char;
      dirty_q <= dirty_d;
      vis_q   <= vis_d;
      div_q   <= div_d;
      blink_q <= blink_d;
      off_q   <= off_d;
      mode_q  <= mode;
      oled_q  <= pix_d;
    end
  end

  assign oled_data = oled_q;

endmodule

// File: tb/tb_game_screen_banner.sv
// Directed bench for game_screen_banner: write/commit, blink, scroll wrap, mode change, async reset.
module tb_game_screen_banner;

  localparam logic [15:0] FG = 16'h07E0;
  localparam logic [15:0] BG = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_begin = 1'b0;
  logic [6:0]  x = '0;
  logic [5:0]  y = '0;
  logic [1:0]  mode = 2'b00;
  logic        wr_en = 1'b0, wr_en6 = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [5:0]  wr_char = '0;
  logic [15:0] oled_data, oled6;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] g_rows [5] = '{4'h7, 4'h8, 4'hB, 4'h9, 4'h7};
  logic [3:0] a_rows [5] = '{4'h6, 4'h9, 4'hF, 4'h9, 4'h9};

  game_screen_banner #(.CHARS(8), .BLINK_FRAMES(2), .SCROLL_DIV(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .x(x), .y(y), .mode(mode),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char), .oled_data(oled_data));

  game_screen_banner #(.CHARS(6), .BLINK_FRAMES(2), .SCROLL_DIV(1)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .frame_begin(frame_begin), .x(x), .y(y), .mode(mode),
    .wr_en(wr_en6), .wr_addr(wr_addr), .wr_char(wr_char), .oled_data(oled6));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic probe(input int px, input int py, output logic [15:0] v, output logic [15:0] v6);
    @(negedge clk);
    x = 7'(px);
    y = 6'(py);
    @(posedge clk);
    #1;
    v  = oled_data;
    v6 = oled6;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_begin = 1'b1;
    @(negedge clk);
    frame_begin = 1'b0;
  endtask

  task automatic write(input int sel6, input int addr, input int ch);
    @(negedge clk);
    wr_addr = 3'(addr);
    wr_char = 6'(ch);
    if (sel6 != 0) wr_en6 = 1'b1; else wr_en = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
    wr_en6 = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] v, v6;
    #3;
    n_checks++;
    if (oled_data !== BG) begin
      n_fail++; $display("FAIL reset_out actual=%h required=%h", oled_data, BG);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 20; c < 24; c++) begin
      probe(c, 7, v, v6);
      n_checks++;
      if (v !== BG) begin
        n_fail++; $display("FAIL reset_blank x=%0d actual=%h required=%h", c, v, BG);
      end
    end
  endtask

  task automatic test_static_write();
    logic [15:0] v, v6, exp;
    mode = 2'b00;
    write(0, 0, 7);
    probe(20, 5, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL static_pre (20,5) actual=%h required=%h", v, BG);
    end
    probe(21, 5, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL static_precommit (21,5) actual=%h required=%h", v, BG);
    end
    frame();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        probe(20 + c, 5 + r, v, v6);
        exp = g_rows[r][3 - c] ? FG : BG;
        n_checks++;
        if (v !== exp) begin
          n_fail++; $display("FAIL static_G (%0d,%0d) actual=%h required=%h", 20 + c, 5 + r, v, exp);
        end
      end
    end
    probe(24, 5, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL static_gap (24,5) actual=%h required=%h", v, BG);
    end
    probe(21, 4, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL static_above_band (21,4) actual=%h required=%h", v, BG);
    end
  endtask

  task automatic test_commit_race();
    logic [15:0] v, v6, exp;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd1; wr_char = 6'd1; frame_begin = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; frame_begin = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        probe(25 + c, 5 + r, v, v6);
        n_checks++;
        if (v !== BG) begin
          n_fail++; $display("FAIL race_hidden (%0d,%0d) actual=%h required=%h", 25 + c, 5 + r, v, BG);
        end
      end
    end
    frame();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        probe(25 + c, 5 + r, v, v6);
        exp = a_rows[r][3 - c] ? FG : BG;
        n_checks++;
        if (v !== exp) begin
          n_fail++; $display("FAIL race_A (%0d,%0d) actual=%h required=%h", 25 + c, 5 + r, v, exp);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [15:0] v, v6, exp;
    write(1, 0, 7);
    frame();
    write(1, 6, 1);
    write(1, 7, 38);
    frame();
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 4; c++) begin
        probe(20 + c, 5 + r, v, v6);
        exp = g_rows[r][3 - c] ? FG : BG;
        n_checks++;
        if (v6 !== exp) begin
          n_fail++; $display("FAIL oor_keep (%0d,%0d) actual=%h required=%h", 20 + c, 5 + r, v6, exp);
        end
      end
    end
    for (int c = 25; c < 55; c++) begin
      probe(c, 7, v, v6);
      n_checks++;
      if (v6 !== BG) begin
        n_fail++; $display("FAIL oor_blank (%0d,7) actual=%h required=%h", c, v6, BG);
      end
    end
  endtask

  task automatic test_blink();
    logic [15:0] v, v6;
    logic [15:0] exp_tab [5] = '{FG, FG, BG, BG, FG};
    @(negedge clk);
    mode = 2'b01;
    for (int f = 0; f < 5; f++) begin
      if (f > 0) frame();
      probe(21, 5, v, v6);
      n_checks++;
      if (v !== exp_tab[f]) begin
        n_fail++; $display("FAIL blink_G frame=%0d actual=%h required=%h", f, v, exp_tab[f]);
      end
      probe(25, 7, v, v6);
      n_checks++;
      if (v !== exp_tab[f]) begin
        n_fail++; $display("FAIL blink_A frame=%0d actual=%h required=%h", f, v, exp_tab[f]);
      end
    end
  endtask

  task automatic test_scroll_wrap();
    logic [15:0] v, v6;
    @(negedge clk);
    mode = 2'b10;
    probe(95, 6, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL scroll_f0 (95,6) actual=%h required=%h", v, BG);
    end
    frame();
    probe(95, 6, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL scroll_f1 (95,6) actual=%h required=%h", v, FG);
    end
    probe(94, 6, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL scroll_f1 (94,6) actual=%h required=%h", v, BG);
    end
    repeat (95) frame();
    probe(0, 6, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL scroll_f96 (0,6) actual=%h required=%h", v, FG);
    end
    probe(1, 7, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL scroll_f96 (1,7) actual=%h required=%h", v, BG);
    end
    probe(2, 7, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL scroll_f96 (2,7) actual=%h required=%h", v, FG);
    end
    probe(5, 7, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL scroll_f96_A (5,7) actual=%h required=%h", v, FG);
    end
    repeat (40) frame();
    for (int r = 5; r < 10; r++) begin
      for (int c = 0; c < 96; c++) begin
        probe(c, r, v, v6);
        n_checks++;
        if (v !== BG) begin
          n_fail++; $display("FAIL scroll_wrap (%0d,%0d) actual=%h required=%h", c, r, v, BG);
        end
      end
    end
    frame();
    probe(95, 6, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL scroll_reenter (95,6) actual=%h required=%h", v, FG);
    end
  endtask

  task automatic test_mode_change();
    logic [15:0] v, v6;
    @(negedge clk);
    mode = 2'b11;
    @(negedge clk);
    repeat (9) frame();
    probe(87, 6, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL mc_f9 (87,6) actual=%h required=%h", v, FG);
    end
    frame();
    probe(86, 6, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL mc_f10_hidden (86,6) actual=%h required=%h", v, BG);
    end
    @(negedge clk);
    mode = 2'b00; frame_begin = 1'b1;
    @(negedge clk);
    frame_begin = 1'b0;
    probe(21, 5, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL mc_static (21,5) actual=%h required=%h", v, FG);
    end
    probe(20, 6, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL mc_static (20,6) actual=%h required=%h", v, FG);
    end
    @(negedge clk);
    mode = 2'b10; frame_begin = 1'b1;
    @(negedge clk);
    frame_begin = 1'b0;
    probe(95, 6, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL mc_priority (95,6) actual=%h required=%h", v, BG);
    end
    frame();
    probe(95, 6, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL mc_after (95,6) actual=%h required=%h", v, FG);
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] v, v6;
    @(negedge clk);
    mode = 2'b00;
    probe(21, 5, v, v6);
    probe(21, 5, v, v6);
    n_checks++;
    if (v !== FG) begin
      n_fail++; $display("FAIL ar_before (21,5) actual=%h required=%h", v, FG);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (oled_data !== BG) begin
      n_fail++; $display("FAIL ar_immediate actual=%h required=%h", oled_data, BG);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    probe(21, 5, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL ar_G_cleared (21,5) actual=%h required=%h", v, BG);
    end
    frame();
    probe(25, 7, v, v6);
    n_checks++;
    if (v !== BG) begin
      n_fail++; $display("FAIL ar_A_cleared (25,7) actual=%h required=%h", v, BG);
    end
    probe(20, 6, v, v6);
    n_checks++;
    if (v6 !== BG) begin
      n_fail++; $display("FAIL ar_dut6_cleared (20,6) actual=%h required=%h", v6, BG);
    end
  endtask

  initial begin
    test_reset();
    test_static_write();
    test_commit_race();
    test_out_of_range();
    test_blink();
    test_scroll_wrap();
    test_mode_change();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
